// File: rtl/adder_cla_pipe.sv
// rtl/adder_cla_pipe.sv - two-stage pipelined carry-lookahead adder/subtractor
//
// Purpose:
//   WIDTH-bit adder/subtractor built from 4-bit lookahead groups.
//   Stage 1 registers per-group generate/propagate and both candidate group
//   sums (carry-in 0 and carry-in 1). Stage 2 resolves the inter-group carries
//   with a flattened second lookahead level, selects the group sums and
//   registers the result. Valid/ready handshake on both sides.
//
// Parameters:
//   WIDTH  operand/sum width, multiple of 4 in 4..64 (default 16)
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   in_valid_i   operands valid
//   in_ready_o   operands can be accepted this cycle
//   a_i, b_i     operands
//   cin_i        carry in (ignored when sub_i=1)
//   sub_i        0: A+B+cin, 1: A-B
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
//   sum_o        result, modulo 2^WIDTH
//   cout_o       carry out of MSB (subtract: 1 = no borrow)
//   g_o, p_o     block-level generate / propagate for cascading
//   ovf_o        signed overflow, present only when ADDER_CLA_OVF_EN is defined
module adder_cla_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             g_o,
  output logic             p_o
`ifdef ADDER_CLA_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int GROUPS = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
    $error("adder_cla_pipe: WIDTH must be a multiple of 4 in 4..64");
  end

  // Carries into each bit of a 4-bit group, given group carry-in ci.
  function automatic logic [3:0] grp_carry(input logic [3:0] g, input logic [3:0] p,
                                           input logic ci);
    logic [3:0] c;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Handshake
  logic rdy_q;
  logic v1_q;
  logic v2_q;
  logic s1_load;
  logic s2_load;
  logic in_xfer;

  // Stage 1
  logic [WIDTH-1:0]       bout_w;
  logic [WIDTH-1:0]       gen_w;
  logic [WIDTH-1:0]       prop_w;
  logic                   c0_d, c0_q;
  logic [GROUPS-1:0][3:0] s0_d, s0_q;
  logic [GROUPS-1:0][3:0] s1_d, s1_q;
  logic [GROUPS-1:0]      gg_d, gg_q;
  logic [GROUPS-1:0]      pp_d, pp_q;

  // Stage 2
  logic [GROUPS:0]        carry;
  logic                   blk_g;
  logic [WIDTH-1:0]       sum_d, sum_q;
  logic                   cout_d, cout_q;
  logic                   g_d, g_q;
  logic                   p_d, p_q;

`ifdef ADDER_CLA_OVF_EN
  logic                   pmsb_d, pmsb_q;
  logic                   ovf_d, ovf_q;
`endif

  assign s2_load    = !v2_q | out_ready_i;
  assign s1_load    = !v1_q | s2_load;
  // rdy_q keeps the input closed during reset and until the first edge after it.
  assign in_ready_o = rdy_q & s1_load;
  assign in_xfer    = in_valid_i & in_ready_o;

  assign bout_w = sub_i ? ~b_i : b_i;
  assign c0_d   = sub_i | cin_i;
  assign gen_w  = a_i & bout_w;
  assign prop_w = a_i ^ bout_w;

  always_comb begin
    s0_d = '0;
    s1_d = '0;
    gg_d = '0;
    pp_d = '0;
    for (int k = 0; k < GROUPS; k++) begin
      s0_d[k] = prop_w[4*k +: 4] ^ grp_carry(gen_w[4*k +: 4], prop_w[4*k +: 4], 1'b0);
      s1_d[k] = prop_w[4*k +: 4] ^ grp_carry(gen_w[4*k +: 4], prop_w[4*k +: 4], 1'b1);
      gg_d[k] = grp_gen(gen_w[4*k +: 4], prop_w[4*k +: 4]);
      pp_d[k] = &prop_w[4*k +: 4];
    end
  end

`ifdef ADDER_CLA_OVF_EN
  assign pmsb_d = prop_w[WIDTH-1];
`endif

  // Each group carry is a sum of products over the registered G/P terms, so no
  // carry depends on another computed carry.
  always_comb begin : s2_carry
    logic t;
    logic acc;
    carry = '0;
    blk_g = 1'b0;
    t     = 1'b0;
    acc   = 1'b0;
    for (int k = 0; k <= GROUPS; k++) begin
      acc = c0_q;
      for (int j = 0; j < k; j++) acc = acc & pp_q[j];
      for (int j = 0; j < k; j++) begin
        t = gg_q[j];
        for (int m = j + 1; m < k; m++) t = t & pp_q[m];
        acc = acc | t;
      end
      carry[k] = acc;
    end
    for (int j = 0; j < GROUPS; j++) begin
      t = gg_q[j];
      for (int m = j + 1; m < GROUPS; m++) t = t & pp_q[m];
      blk_g = blk_g | t;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < GROUPS; k++) begin
      sum_d[4*k +: 4] = carry[k] ? s1_q[k] : s0_q[k];
    end
  end

  assign cout_d = carry[GROUPS];
  assign g_d    = blk_g;
  assign p_d    = &pp_q;

`ifdef ADDER_CLA_OVF_EN
  // Carry into the MSB is recovered as sum_msb ^ p_msb.
  assign ovf_d = carry[GROUPS] ^ sum_d[WIDTH-1] ^ pmsb_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_q  <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      c0_q   <= 1'b0;
      s0_q   <= '0;
      s1_q   <= '0;
      gg_q   <= '0;
      pp_q   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      g_q    <= 1'b0;
      p_q    <= 1'b0;
`ifdef ADDER_CLA_OVF_EN
      pmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      rdy_q <= 1'b1;
      if (s1_load) begin
        v1_q <= in_xfer;
        if (in_xfer) begin
          c0_q <= c0_d;
          s0_q <= s0_d;
          s1_q <= s1_d;
          gg_q <= gg_d;
          pp_q <= pp_d;
`ifdef ADDER_CLA_OVF_EN
          pmsb_q <= pmsb_d;
`endif
        end
      end
      if (s2_load) begin
        v2_q <= v1_q;
        // Data registers only move on a real item, so outputs keep their last value across bubbles.
        if (v1_q) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          g_q    <= g_d;
          p_q    <= p_d;
`ifdef ADDER_CLA_OVF_EN
          ovf_q  <= ovf_d;
`endif
        end
      end
    end
  end

  assign out_valid_o = v2_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign g_o         = g_q;
  assign p_o         = p_q;
`ifdef ADDER_CLA_OVF_EN
  assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_adder_cla_pipe.sv
// tb/tb_adder_cla_pipe.sv - self-checking bench for adder_cla_pipe (WIDTH=16)
module tb_adder_cla_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, g, p;
`ifdef ADDER_CLA_OVF_EN
  logic         ovf;
`endif

  adder_cla_pipe #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .sub_i      (sub),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_o      (sum),
    .cout_o     (cout),
    .g_o        (g),
    .p_o        (p)
`ifdef ADDER_CLA_OVF_EN
    ,
    .ovf_o      (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         g;
    logic         p;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         g;
    logic         p;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   first_out = -1;
  int   last_out = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    exp_t         e;
    logic [W-1:0] bo;
    logic         c0;
    logic [W:0]   full;
    logic [W:0]   nocin;
    bo    = msub ? ~mb : mb;
    c0    = msub ? 1'b1 : mcin;
    full  = {1'b0, ma} + {1'b0, bo} + {{W{1'b0}}, c0};
    nocin = {1'b0, ma} + {1'b0, bo};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.g    = nocin[W];
    e.p    = &(ma ^ bo);
    e.ovf  = (ma[W-1] == bo[W-1]) && (full[W-1] != ma[W-1]);
    return e;
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_output actual=%0h expected=none", sum);
        end else begin
          e = sbq.pop_front();
          check("sb_sum", 32'(sum), 32'(e.sum));
          check("sb_cout", 32'(cout), 32'(e.cout));
          check("sb_g", 32'(g), 32'(e.g));
          check("sb_p", 32'(p), 32'(e.p));
`ifdef ADDER_CLA_OVF_EN
          check("sb_ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
        out_cnt++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && in_ready) sbq.push_back(model(a, b, cin, sub));
    end
  end

  task automatic run_one(input vec_t v, output exp_t got, output int lat);
    @(posedge clk); #1;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    got.sum = 'x; got.cout = 1'bx; got.g = 1'bx; got.p = 1'bx; got.ovf = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        got.sum = sum; got.cout = cout; got.g = g; got.p = p;
`ifdef ADDER_CLA_OVF_EN
        got.ovf = ovf;
`endif
        break;
      end
    end
  endtask

  vec_t vecs[10];
  exp_t got;
  int   lat;
  int   acc;
  logic [W-1:0] held_sum;
  logic saw_valid;

  initial begin
    //           a        b        cin   sub   sum      cout  g     p     ovf
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_g", 32'(g), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors, one at a time, with latency check.
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i], got, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_sum", i), 32'(got.sum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_cout", i), 32'(got.cout), 32'(vecs[i].cout));
      check($sformatf("vec%0d_g", i), 32'(got.g), 32'(vecs[i].g));
      check($sformatf("vec%0d_p", i), 32'(got.p), 32'(vecs[i].p));
`ifdef ADDER_CLA_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(got.ovf), 32'(vecs[i].ovf));
`endif
    end

    // Back-to-back stream of 8 random pairs.
    repeat (3) @(posedge clk);
    out_cnt = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("stream_count", 32'(out_cnt), 32'd8);
    check("stream_consecutive", 32'(last_out - first_out), 32'd7);

    // Backpressure: out_ready low for 5 cycles with input offered every cycle.
    out_ready = 1'b0; acc = 0; out_cnt = 0; held_sum = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      if (i == 2) held_sum = sum;
      if (i > 2) begin
        check($sformatf("stall_sum_hold%0d", i), 32'(sum), 32'(held_sum));
        check($sformatf("stall_valid%0d", i), 32'(out_valid), 32'd1);
      end
    end
    check("stall_accepts", 32'(acc), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_drain_count", 32'(out_cnt), 32'd2);
    check("stall_sb_empty", 32'(sbq.size()), 32'd0);

    // Reset with two items in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("inflight_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("postrst_no_stale", 32'(saw_valid), 32'd0);

    run_one(vecs[0], got, lat);
    check("postrst_latency", 32'(lat), 32'd2);
    check("postrst_sum", 32'(got.sum), 32'(vecs[0].sum));
    repeat (2) @(negedge clk);
    check("final_sb_empty", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_cla_pipe.md
Name: adder_cla_pipe

Overview:
- Parametrised carry-lookahead adder/subtractor, the multi-group successor to the team's 4-bit lookahead adder slice.
- WIDTH is split into 4-bit lookahead groups. Stage 1 registers per-group generate/propagate and pre-sums. Stage 2 resolves inter-group carries with a second lookahead level and registers the final sum.
- Valid/ready handshake on both sides. Intended for ALU and accumulator datapaths that need fmax beyond a ripple of 4-bit slices.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4, range 4..64. Any other value triggers an elaboration-time $error.
- GROUPS, WIDTH/4, derived (localparam); number of 4-bit lookahead groups.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- in_valid_i  input  1  operands valid
- in_ready_o  output  1  block can accept operands this cycle
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry in; ignored when sub_i=1
- sub_i  input  1  0: A+B+cin; 1: A-B (A + ~B + 1)
- out_valid_o  output  1  result valid
- out_ready_i  input  1  downstream accepts result
- sum_o  output  WIDTH  result
- cout_o  output  1  carry out of MSB; for subtract, 1 means no borrow
- g_o  output  1  block-level generate, for cascading
- p_o  output  1  block-level propagate, for cascading

Behaviour:
- Reset (async, on assertion): both stage valid flags = 0; out_valid_o=0; sum_o=0; cout_o=0; g_o=0; p_o=0. in_ready_o=1 once the first edge after deassertion occurs.
- Transfers:
  - Input transfer = in_valid_i & in_ready_o.
  - Output transfer = out_valid_o & out_ready_i.
- Stage 1 (S1), on input transfer:
  - Bout = sub_i ? ~b_i : b_i; c0 = sub_i ? 1 : cin_i.
  - Per bit: g = a & Bout, p = a ^ Bout.
  - Per group k: local sum assuming carry-in 0 (s0_k) and assuming carry-in 1 (s1_k); group G_k and P_k from the standard 4-bit lookahead equations.
  - Registers s0, s1, G, P, c0 and v1.
- Stage 2 (S2):
  - Inter-group carries: C_0 = c0; C_{k+1} = G_k | (P_k & C_k), computed as a flattened lookahead (no ripple through group registers).
  - sum group k = C_k ? s1_k : s0_k.
  - cout = C_GROUPS. g_o = block generate; p_o = AND of all P_k.
  - Registers outputs and v2 (= out_valid_o).
- Latency: exactly 2 cycles from input transfer to out_valid_o when there is no stall. Throughput: 1 result per cycle.
- Backpressure:
  - S2 loads when !v2 | out_ready_i.
  - S1 loads when !v1 | S2 loads.
  - in_ready_o = !v1 | (!v2 | out_ready_i). This is combinational from out_ready_i, with no other comb path input to output.
- Stall: while out_valid_o=1 & out_ready_i=0, sum_o, cout_o, g_o and p_o hold stable, and S1 holds its contents. No data loss, no duplication.
- Bubbles: S1 empty and S2 draining → v2 clears after the transfer. Outputs keep their last value; they are don't-care when invalid, but must not be X after reset.
- Wrap-around: the sum is modulo 2^WIDTH; the carry appears only on cout_o. Example: 0xFFFF + 0x0001 gives sum 0x0000, cout 1.
- Reset mid-operation: in-flight results are discarded; no out_valid_o pulse after reset deassertion.
- Simultaneous input transfer and output transfer with both stages full: the pipeline advances by one; occupancy stays 2.

Optional Feature:
- Macro: ADDER_CLA_OVF_EN.
- When defined: extra output ovf_o (1 bit) = signed overflow = C_GROUPS ^ carry into MSB, registered in S2. It follows the same hold, stall and reset (0) rules as sum_o.
- When undefined: port absent; no extra logic.

Test Plan:
- WIDTH=16, reset asserted mid-stream with 2 items in flight → out_valid_o=0 immediately, sum_o=0, no stale output after release.
- 0x1234 + 0x4321, cin=0, sub=0, out_ready_i=1 → two cycles later out_valid_o=1, sum_o=0x5555, cout_o=0, p_o=0.
- 0xFFFF + 0x0000, cin=1 → sum_o=0x0000, cout_o=1, p_o=1, g_o=0. Then 0x0005 - 0x0007, sub=1 → sum_o=0xFFFE, cout_o=0 (borrow).
- Back-to-back stream of 8 random operand pairs with in_valid_i=1 → 8 results on 8 consecutive cycles in order, all matching the reference model.
- Hold out_ready_i=0 for 5 cycles with in_valid_i=1 → in_ready_o drops after 2 accepts, sum_o stable. Release → both results drain in order, none lost.
- With ADDER_CLA_OVF_EN: 0x7FFF + 0x0001 → ovf_o=1, sum_o=0x8000. Then 0x8000 - 0x0001 → ovf_o=1, sum_o=0x7FFF.
